dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port synchronous data RAM (dram).
- Master 0 is the CPU load/store stage; master 1 is the program/data loader or debug port.
- Each master uses a req/ack handshake. The block grants one master at a time, drives exactly one RAM access per grant, captures read data and returns a one-cycle ack.

Parameters:
- ADDR_W, 11, RAM word address width.
- DATA_W, 16, RAM data width, for both read and write.
- RD_LATENCY, 1, clocks from the RAM cs edge to valid read_data (1..3).
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins contention.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request; held high until m0_ack is sampled.
- m0_rnw  in  1  master 0: 1 = read, 0 = write.
- m0_addr  in  ADDR_W  master 0 word address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_rdata  out  DATA_W  read data for master 0; valid while m0_ack=1, then held.
- m1_req, m1_rnw, m1_addr, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1.
- ram_address  out  ADDR_W  address to the RAM.
- ram_write_data  out  DATA_W  write data to the RAM.
- ram_read_data  in  DATA_W  read data from the RAM.
- ram_read_not_write  out  1  RAM direction: 1 = read.
- ram_cs  out  1  RAM chip select, high for exactly one clock per access.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, ram_cs=0, ram_read_not_write=1, ram_address=0, ram_write_data=0.
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, last_grant=1 (master 0 wins the first contention).
- Reset mid-transaction: the access is aborted and cs drops immediately. No ack is issued; requesters must reissue.
- IDLE:
  - If any req is high, select a winner. The winner's rnw/addr/wdata are latched into internal registers on the same edge. Go to ISSUE.
  - Contention with FIXED_PRIO=0: the grant goes to the master not equal to last_grant. last_grant updates on the grant edge.
  - Contention with FIXED_PRIO=1: master 0 always wins.
- ISSUE (1 cycle): ram_cs=1 and the RAM signals are driven from the latched registers. Next state is WAIT for a read, ACK for a write.
- WAIT (RD_LATENCY cycles): a counter counts down. On the final WAIT edge, ram_read_data is captured into the granted master's rdata register. Go to ACK.
- ACK (1 cycle): the granted master's ack=1 and the other master's ack stays 0. Go to IDLE.
- The requester deasserts req on the edge where it samples ack=1. A req still high in IDLE is treated as a new transaction.
- Latency from req sampled in IDLE to ack high:
  - write: 2 cycles;
  - read: 2+RD_LATENCY cycles.
- Requests never overlap: a req arriving during ISSUE/WAIT/ACK waits until IDLE. The non-granted req is never dropped.
- Input inputs are latched at grant; changes to addr/wdata/rnw after grant are ignored.
- Outside ISSUE, ram_cs=0 and ram_read_not_write=1; ram_address and ram_write_data hold their last values.
- rdata of the non-granted master is never modified.
- Address and data pass through unmodified; there is no arithmetic or bounds checking. Every ADDR_W value is legal.

Decomposition:
- Package dram_arb_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT, ACK};
  - localparams ADDR_W_DEF=11, DATA_W_DEF=16;
  - the master-index constants M0=0, M1=1.
- One sub-module, rr_arb2: a 2-input round-robin/fixed-priority grant with a last_grant register.
  - Inputs: req[1:0], grant_en, FIXED_PRIO.
  - Outputs: gnt_idx.

Test Plan:
- Write m0 addr=16 wdata=63, then m1 write addr=24 wdata=10 -> each ack exactly 2 cycles after req sampled; ram_cs one cycle each with the correct address and data.
- m1 read addr=16 (RD_LATENCY=1) -> m1_ack at 3 cycles, m1_rdata=63; m0_rdata unchanged (0).
- Both masters req read in the same cycle (m0 addr=24, m1 addr=16), twice:
  - first round: m0 granted first, then m1;
  - second round: m1 granted first;
  - rdata=10 and 63 routed to the correct masters.
- FIXED_PRIO=1, both reqs held continuously -> m0 is served back-to-back; m1 is served only after m0 drops req.
- Assert rst during WAIT of a read -> ram_cs=0, all acks 0 and rdata 0 immediately. After release, a reissued read completes normally.
- RD_LATENCY=3: read addr=24 -> ack at 5 cycles, rdata=10; a changing m0_addr mid-transaction does not alter ram_address.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the dram arbiter slice.
package dram_arb_pkg;

    // Sequencer states: one RAM access per grant.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;

    // Master indices as used by the grant logic.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage : dram_arb_pkg

// File: rtl/dram_arbiter_rr_arb2.sv
// Two-input grant selector: round-robin or fixed priority (master 0 first).
module rr_arb2
    import dram_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       gnt_idx
);

    logic last_grant;

    // Pick the winner; only true contention consults last_grant.
    always_comb begin
        // NOTE: default first so every path assigns gnt_idx and no latch is inferred.
        gnt_idx = M0;
        if (req == 2'b11) begin
            gnt_idx = FIXED_PRIO ? M0 : ~last_grant;
        end else if (req[1]) begin
            gnt_idx = M1;
        end
    end

    // Remember who won the last contended grant; uncontested grants leave it alone
    // so the loser of the previous contention is favoured next time.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for all clocked state avoid simulation races.
        if (rst) begin
            last_grant <= M1;
        end else if (grant_en && (req == 2'b11)) begin
            last_grant <= gnt_idx;
        end
    end

endmodule : rr_arb2

// File: rtl/dram_arbiter.sv
// Two-master req/ack arbiter and sequencer for the single-port data RAM.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_rnw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_rnw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic              ram_read_not_write,
    output logic              ram_cs
);

    state_t      state;
    logic        gnt;       // master owning the current access
    logic        lat_rnw;   // direction latched at grant
    logic [1:0]  wait_cnt;  // remaining read-latency cycles
    logic        gnt_idx;
    logic        sel_rnw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO != 0)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({m1_req, m0_req}),
        .grant_en(state == IDLE),
        .gnt_idx (gnt_idx)
    );

    // Request fields of the master about to be granted.
    assign sel_rnw   = (gnt_idx == M1) ? m1_rnw   : m0_rnw;
    assign sel_addr  = (gnt_idx == M1) ? m1_addr  : m0_addr;
    assign sel_wdata = (gnt_idx == M1) ? m1_wdata : m0_wdata;

    // Sequencer: grant, one-cycle RAM strobe, read wait, one-cycle ack.
    // ram_address/ram_write_data double as the latched request and hold between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            gnt                <= M0;
            lat_rnw            <= 1'b1;
            wait_cnt           <= '0;
            ram_cs             <= 1'b0;
            ram_read_not_write <= 1'b1;
            ram_address        <= '0;
            ram_write_data     <= '0;
            m0_ack             <= 1'b0;
            m1_ack             <= 1'b0;
            m0_rdata           <= '0;
            m1_rdata           <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt                <= gnt_idx;
                        lat_rnw            <= sel_rnw;
                        ram_address        <= sel_addr;
                        ram_write_data     <= sel_wdata;
                        ram_read_not_write <= sel_rnw;
                        ram_cs             <= 1'b1;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_cs             <= 1'b0;
                    ram_read_not_write <= 1'b1;
                    wait_cnt           <= 2'(RD_LATENCY - 1);
                    if (lat_rnw) begin
                        state <= WAIT;
                    end else begin
                        state <= ACK;
                        if (gnt == M1) m1_ack <= 1'b1;
                        else           m0_ack <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= ACK;
                        if (gnt == M1) begin
                            m1_rdata <= ram_read_data;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= ram_read_data;
                            m0_ack   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : dram_arbiter

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: three instances (round-robin RL=1, fixed-priority RL=1,
// round-robin RL=3), each with its own behavioural synchronous RAM.
module tb_dram_arbiter;

    typedef struct {
        int          inst;
        bit          m;
        bit          rnw;
        bit          scr;    // corrupt the master's inputs right after grant
        logic [10:0] addr;
        logic [15:0] wdata;
        int          lat;    // edges from the req-sampling edge to ack visible
        logic [15:0] rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst [3];
    logic        m0_req [3];
    logic        m0_rnw [3];
    logic [10:0] m0_addr [3];
    logic [15:0] m0_wdata [3];
    logic        m0_ack [3];
    logic [15:0] m0_rdata [3];
    logic        m1_req [3];
    logic        m1_rnw [3];
    logic [10:0] m1_addr [3];
    logic [15:0] m1_wdata [3];
    logic        m1_ack [3];
    logic [15:0] m1_rdata [3];
    logic [10:0] ram_address [3];
    logic [15:0] ram_write_data [3];
    logic [15:0] ram_read_data [3];
    logic        ram_read_not_write [3];
    logic        ram_cs [3];

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vecs [11];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int RL = (g == 2) ? 3 : 1;
        logic [15:0] mem  [0:2047];
        logic [15:0] pipe [0:2];

        dram_arbiter #(
            .ADDR_W    (11),
            .DATA_W    (16),
            .RD_LATENCY(RL),
            .FIXED_PRIO((g == 1) ? 1 : 0)
        ) u_dut (
            .clk               (clk),
            .rst               (rst[g]),
            .m0_req            (m0_req[g]),
            .m0_rnw            (m0_rnw[g]),
            .m0_addr           (m0_addr[g]),
            .m0_wdata          (m0_wdata[g]),
            .m0_ack            (m0_ack[g]),
            .m0_rdata          (m0_rdata[g]),
            .m1_req            (m1_req[g]),
            .m1_rnw            (m1_rnw[g]),
            .m1_addr           (m1_addr[g]),
            .m1_wdata          (m1_wdata[g]),
            .m1_ack            (m1_ack[g]),
            .m1_rdata          (m1_rdata[g]),
            .ram_address       (ram_address[g]),
            .ram_write_data    (ram_write_data[g]),
            .ram_read_data     (ram_read_data[g]),
            .ram_read_not_write(ram_read_not_write[g]),
            .ram_cs            (ram_cs[g])
        );

        // Synchronous RAM: read data appears RL clocks after the cs edge.
        always @(posedge clk) begin
            if (ram_cs[g]) begin
                if (ram_read_not_write[g]) pipe[0] <= mem[ram_address[g]];
                else mem[ram_address[g]] <= ram_write_data[g];
            end
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign ram_read_data[g] = pipe[RL-1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input bit m, input logic req, input logic rnw,
                         input logic [10:0] a, input logic [15:0] d);
        if (m) begin
            m1_req[k] = req; m1_rnw[k] = rnw; m1_addr[k] = a; m1_wdata[k] = d;
        end else begin
            m0_req[k] = req; m0_rnw[k] = rnw; m0_addr[k] = a; m0_wdata[k] = d;
        end
    endtask

    function automatic logic ack_of(input int k, input bit m);
        return m ? m1_ack[k] : m0_ack[k];
    endfunction

    function automatic logic [15:0] rdata_of(input int k, input bit m);
        return m ? m1_rdata[k] : m0_rdata[k];
    endfunction

    function automatic vec_t mk(input int inst, input bit m, input bit rnw, input bit scr,
                                input logic [10:0] a, input logic [15:0] d, input int lat,
                                input logic [15:0] rd);
        vec_t v;
        v.inst = inst; v.m = m; v.rnw = rnw; v.scr = scr;
        v.addr = a; v.wdata = d; v.lat = lat; v.rdata = rd;
        return v;
    endfunction

    // One transaction from IDLE through ACK, returning with the DUT back in IDLE.
    task automatic do_txn(input vec_t v, input string tag);
        int          cyc = 0;
        int          cs_cnt = 0;
        logic        got = 1'b0;
        logic        other_ack = 1'b0;
        logic [10:0] cs_addr = '0;
        logic [15:0] cs_wd = '0;
        logic        cs_rnw = 1'b0;
        drive(v.inst, v.m, 1'b1, v.rnw, v.addr, v.wdata);
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1 && v.scr) drive(v.inst, v.m, 1'b1, ~v.rnw, ~v.addr, ~v.wdata);
            if (ram_cs[v.inst]) begin
                cs_cnt++;
                cs_addr = ram_address[v.inst];
                cs_wd   = ram_write_data[v.inst];
                cs_rnw  = ram_read_not_write[v.inst];
            end
            if (ack_of(v.inst, !v.m)) other_ack = 1'b1;
            if (ack_of(v.inst, v.m)) got = 1'b1;
        end
        drive(v.inst, v.m, 1'b0, 1'b0, '0, '0);
        check({tag, " ack latency"}, got ? cyc : 999, v.lat);
        check({tag, " cs strobes"}, cs_cnt, 1);
        check({tag, " ram_address"}, cs_addr, v.addr);
        check({tag, " ram_read_not_write"}, cs_rnw, v.rnw);
        check({tag, " other ack"}, other_ack, 1'b0);
        if (!v.rnw) check({tag, " ram_write_data"}, cs_wd, v.wdata);
        else        check({tag, " rdata"}, rdata_of(v.inst, v.m), v.rdata);
        @(posedge clk); #1;
    endtask

    // Both masters read in the same cycle; m0 reads addr 24, m1 reads addr 16.
    task automatic contend(input bit exp_first, input string tag);
        int   cyc = 0;
        int   n_done = 0;
        logic first = 1'b0;
        drive(0, 1'b0, 1'b1, 1'b1, 11'd24, '0);
        drive(0, 1'b1, 1'b1, 1'b1, 11'd16, '0);
        while (n_done < 2 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            for (int m = 0; m < 2; m++) begin
                if (ack_of(0, m[0])) begin
                    if (n_done == 0) first = m[0];
                    n_done++;
                    drive(0, m[0], 1'b0, 1'b0, '0, '0);
                end
            end
        end
        check({tag, " both served"}, n_done, 2);
        check({tag, " first grant"}, first, exp_first);
        check({tag, " m0_rdata"}, m0_rdata[0], 16'd10);
        check({tag, " m1_rdata"}, m1_rdata[0], 16'd63);
        @(posedge clk); #1;
    endtask

    initial begin
        int   cyc;
        int   m0_cnt;
        int   m0_t [3];
        int   m0_at_m1;
        logic saw;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
            drive(k, 1'b1, 1'b0, 1'b0, '0, '0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("i%0d reset ram_cs", k), ram_cs[k], 1'b0);
            check($sformatf("i%0d reset ram_read_not_write", k), ram_read_not_write[k], 1'b1);
            check($sformatf("i%0d reset ram_address", k), ram_address[k], '0);
            check($sformatf("i%0d reset ram_write_data", k), ram_write_data[k], '0);
            check($sformatf("i%0d reset acks", k), {m0_ack[k], m1_ack[k]}, 2'b00);
            check($sformatf("i%0d reset rdata", k), {m0_rdata[k], m1_rdata[k]}, '0);
            rst[k] = 1'b0;
        end
        @(posedge clk); #1;

        // Single transactions; latency 2 for writes, 2+RD_LATENCY for reads.
        vecs[0]  = mk(0, 1'b0, 1'b0, 1'b0, 11'd16,   16'd63,     2, 16'd0);
        vecs[1]  = mk(0, 1'b1, 1'b0, 1'b0, 11'd24,   16'd10,     2, 16'd0);
        vecs[2]  = mk(0, 1'b1, 1'b1, 1'b0, 11'd16,   16'd0,      3, 16'd63);
        vecs[3]  = mk(0, 1'b0, 1'b0, 1'b0, 11'd2047, 16'hFFFF,   2, 16'd0);
        vecs[4]  = mk(0, 1'b1, 1'b1, 1'b0, 11'd2047, 16'd0,      3, 16'hFFFF);
        vecs[5]  = mk(1, 1'b0, 1'b0, 1'b0, 11'd24,   16'd10,     2, 16'd0);
        vecs[6]  = mk(1, 1'b1, 1'b0, 1'b0, 11'd16,   16'd63,     2, 16'd0);
        vecs[7]  = mk(2, 1'b0, 1'b0, 1'b0, 11'd24,   16'd10,     2, 16'd0);
        vecs[8]  = mk(2, 1'b1, 1'b0, 1'b1, 11'd7,    16'h1234,   2, 16'd0);
        vecs[9]  = mk(2, 1'b0, 1'b1, 1'b1, 11'd24,   16'd0,      5, 16'd10);
        vecs[10] = mk(2, 1'b0, 1'b1, 1'b0, 11'd7,    16'd0,      5, 16'h1234);
        for (int i = 0; i < 11; i++) do_txn(vecs[i], $sformatf("v%0d", i));

        check("i0 m0_rdata untouched by m1 reads", m0_rdata[0], 16'd0);
        check("i2 m1_rdata untouched by m0 reads", m1_rdata[2], 16'd0);
        check("i2 ram_address holds after access", ram_address[2], 11'd7);

        // Round-robin contention: m0 wins first, the loser wins the next contention.
        contend(1'b0, "rr round1");
        contend(1'b1, "rr round2");

        // Fixed priority: m0 keeps winning while it holds req; m1 goes after m0 drops.
        drive(1, 1'b0, 1'b1, 1'b1, 11'd24, '0);
        drive(1, 1'b1, 1'b1, 1'b1, 11'd16, '0);
        cyc = 0; m0_cnt = 0; m0_at_m1 = -1;
        while (m0_at_m1 < 0 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (m0_ack[1]) begin
                if (m0_cnt < 3) m0_t[m0_cnt] = cyc;
                m0_cnt++;
                if (m0_cnt == 3) drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
            end
            if (m1_ack[1]) begin
                m0_at_m1 = m0_cnt;
                drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
            end
        end
        check("fp m0 grants before m1", m0_at_m1, 3);
        check("fp back-to-back spacing", m0_t[1] - m0_t[0], 4);
        check("fp m0_rdata", m0_rdata[1], 16'd10);
        check("fp m1_rdata", m1_rdata[1], 16'd63);
        @(posedge clk); #1;

        // Reset during WAIT aborts the read and clears outputs without a clock edge.
        drive(0, 1'b0, 1'b1, 1'b1, 11'd24, '0);
        @(posedge clk); #1;
        check("rst pre ram_cs in ISSUE", ram_cs[0], 1'b1);
        @(posedge clk); #1;
        rst[0] = 1'b1;
        #1;
        check("rst ram_cs", ram_cs[0], 1'b0);
        check("rst acks", {m0_ack[0], m1_ack[0]}, 2'b00);
        check("rst m0_rdata", m0_rdata[0], 16'd0);
        check("rst m1_rdata", m1_rdata[0], 16'd0);
        check("rst ram_address", ram_address[0], 11'd0);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (m0_ack[0] || m1_ack[0] || ram_cs[0]) saw = 1'b1;
        end
        check("no ack or access after aborted read", saw, 1'b0);
        do_txn(mk(0, 1'b0, 1'b1, 1'b0, 11'd24, 16'd0, 3, 16'd10), "reissue");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dram_arbiter
